mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-port, fixed-latency SRAM between the IF stage (instruction fetch) and the MEM stage (load/store).
- Sequences each access with a wait-state counter and returns per-requester ready pulses.
- Drives freeze outputs that stall the IF stage and the EXE/MEM pipeline registers while their access is outstanding.
- Sits between IF_stage / MEM_stage and the external SRAM model.

Parameters:
- ADDR_W, 32, byte-address width of requester addresses
- DATA_W, 32, data word width
- SRAM_AW, 16, SRAM word-address width
- WAIT_CYCLES, 4, SRAM access latency in cycles; legal range 1..15
- DATA_BASE, 1024, byte offset subtracted from MEM-stage addresses before mapping

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset, asynchronous, active-low
- if_req  in  1  fetch request
- if_addr  in  ADDR_W  fetch byte address
- if_rdata  out  DATA_W  fetched instruction
- if_ready  out  1  one-cycle completion pulse for fetch
- if_freeze  out  1  stall IF stage
- mem_r_en  in  1  load request
- mem_w_en  in  1  store request
- mem_addr  in  ADDR_W  data byte address
- mem_wdata  in  DATA_W  store data
- mem_rdata  out  DATA_W  load data
- mem_ready  out  1  one-cycle completion pulse for data access
- mem_freeze  out  1  stall EXE/MEM pipeline registers
- sram_addr  out  SRAM_AW  SRAM word address
- sram_wdata  out  DATA_W  SRAM write data
- sram_rdata  in  DATA_W  SRAM read data, valid in the final wait cycle
- sram_we  out  1  SRAM write enable
- sram_oe  out  1  SRAM output enable

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; counter 0; all outputs 0, including sram_we and sram_oe, which drop immediately. Reset mid-access abandons the access; no ready pulse follows.
- FSM states: IDLE, ACCESS, DONE.
- IDLE: sample requests each cycle.
  - Data request (mem_r_en|mem_w_en) → grant MEM.
  - Otherwise if_req → grant IF.
  - On grant, register owner, operation, address, write data and WORD; load counter = WAIT_CYCLES-1; go to ACCESS.
- Priority: MEM always beats IF, because MEM holds the older instruction. With both requesting in IDLE, IF waits until the MEM access completes.
- Address mapping:
  - IF: sram_addr = if_addr[SRAM_AW+1:2].
  - MEM: sram_addr = (mem_addr - DATA_BASE)[SRAM_AW+1:2].
  - Low two bits are ignored; wrap-around modulo 2^SRAM_AW is accepted.
- ACCESS:
  - sram_addr and sram_wdata are held stable from registers.
  - sram_we=1 for a write; sram_oe=1 for a read.
  - Counter decrements each cycle. At counter==0, capture sram_rdata into the owner's rdata register, deassert SRAM strobes, and go to DONE.
  - ACCESS lasts exactly WAIT_CYCLES cycles.
- DONE: pulse owner's ready for one cycle → IDLE. No grant occurs in DONE, so there is one idle cycle between back-to-back accesses.
- Latency: request sampled at edge N → ready high during cycle N+WAIT_CYCLES+1.
- Freeze (combinational):
  - mem_freeze = (mem_r_en|mem_w_en) & ~mem_ready.
  - if_freeze = if_req & ~if_ready, OR'd with mem_freeze.
- rdata outputs hold their last captured value until overwritten. A write leaves mem_rdata unchanged.
- mem_r_en and mem_w_en both high: treated as a write.
- IF request withdrawn or address changed mid-access (branch flush): the access runs to completion. if_ready is suppressed unless if_req=1 and if_addr matches the latched address, so a stale instruction is never returned.
- MEM requests are never withdrawn while mem_freeze is high. This is a requester obligation; the arbiter does not check it.

Optional Feature:
- Macro MEM_ARB_PERF_EN.
- Defined: adds outputs perf_if_stall[31:0] and perf_mem_stall[31:0].
  - Each counts cycles in which the corresponding freeze is high.
  - Counters saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package arm_mem_pkg holds:
  - state enum (IDLE, ACCESS, DONE)
  - owner enum (OWN_IF, OWN_MEM)
  - DATA_BASE and WAIT_CYCLES defaults
- Sub-module arb_wait_counter: load value, decrement, zero flag; asynchronous active-low reset.

Test Plan:
- WAIT_CYCLES=4; if_req=1, if_addr=0x8, SRAM word 2=0xE3A00001 → sram_oe high 4 cycles, sram_addr=2; if_ready on cycle 6 with if_rdata=0xE3A00001; if_freeze high cycles 1-5.
- Store mem_w_en=1, mem_addr=1028, mem_wdata=0x1234 → sram_addr=1, sram_we high 4 cycles; mem_ready pulse; SRAM word 1=0x1234. Follow-up load from same address → mem_rdata=0x1234.
- if_req and mem_r_en asserted same cycle → MEM served first. IF grant only after MEM DONE plus IDLE; if_freeze stays high throughout.
- IF access to 0x10, if_addr changed to 0x40 in cycle 2 → no if_ready for 0x10. Next access fetches word 0x10 (addr 0x40); if_rdata is never the stale word.
- rst low during ACCESS with sram_we=1 → sram_we=0 immediately, state IDLE, no ready pulse after release.
- MEM_ARB_PERF_EN defined, three back-to-back fetches → perf_if_stall = 3·(WAIT_CYCLES+1) = 15; perf_mem_stall = 0.

Source files
------------

// File: rtl/arm_mem_pkg.sv
// Shared types and defaults for the IF/MEM single-port SRAM arbiter.
package arm_mem_pkg;

   localparam int WAIT_CYCLES_DEF = 4;
   localparam int DATA_BASE_DEF   = 1024;
   localparam int CNT_W           = 4;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      DONE
   } state_t;

   typedef enum logic {
      OWN_IF,
      OWN_MEM
   } owner_t;

endpackage

// File: rtl/arb_wait_counter.sv
// Wait-state down-counter: load on grant, decrement during the access, zero flag ends it.
module arb_wait_counter
   import arm_mem_pkg::*;
#(
   parameter int W = CNT_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_dec,
   output logic         o_zero
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_cnt <= '0;
      else if (i_load)
         r_cnt <= i_load_val;
      else if (i_dec && (r_cnt != '0))
         r_cnt <= r_cnt - 1'b1;
   end

   assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one fixed-latency SRAM between instruction fetch and load/store, MEM first.
// Optional stall counters are built when MEM_ARB_PERF_EN is defined.
module mem_arbiter
   import arm_mem_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int SRAM_AW     = 16,
   parameter int WAIT_CYCLES = WAIT_CYCLES_DEF,
   parameter int DATA_BASE   = DATA_BASE_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               if_req,
   input  logic [ADDR_W-1:0]  if_addr,
   output logic [DATA_W-1:0]  if_rdata,
   output logic               if_ready,
   output logic               if_freeze,
   input  logic               mem_r_en,
   input  logic               mem_w_en,
   input  logic [ADDR_W-1:0]  mem_addr,
   input  logic [DATA_W-1:0]  mem_wdata,
   output logic [DATA_W-1:0]  mem_rdata,
   output logic               mem_ready,
   output logic               mem_freeze,
   output logic [SRAM_AW-1:0] sram_addr,
   output logic [DATA_W-1:0]  sram_wdata,
   input  logic [DATA_W-1:0]  sram_rdata,
   output logic               sram_we,
   output logic               sram_oe
`ifdef MEM_ARB_PERF_EN
  ,output logic [31:0]        perf_if_stall,
   output logic [31:0]        perf_mem_stall
`endif
);

   state_t             r_state, w_next;
   owner_t             r_owner;
   logic               r_we;
   logic [SRAM_AW-1:0] r_addr;
   logic [DATA_W-1:0]  r_wdata;
   logic [ADDR_W-1:0]  r_if_addr;
   logic [DATA_W-1:0]  r_if_rdata, r_mem_rdata;
   logic               w_grant, w_cnt_zero, w_mem_req, w_access, w_done;
   logic [ADDR_W-1:0]  w_mem_off;
   logic               w_unused;

   assign w_mem_req = mem_r_en | mem_w_en;
   assign w_mem_off = mem_addr - ADDR_W'(DATA_BASE);
   assign w_unused  = ^{w_mem_off[ADDR_W-1:SRAM_AW+2], w_mem_off[1:0]};
   assign w_access  = (r_state == ACCESS);
   assign w_done    = (r_state == DONE);

   arb_wait_counter #(.W(CNT_W)) u_wait (
      .clk        (clk),
      .rst_n      (rst),
      .i_load     (w_grant),
      .i_load_val (CNT_W'(WAIT_CYCLES - 1)),
      .i_dec      (w_access),
      .o_zero     (w_cnt_zero)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_state <= IDLE;
      else
         r_state <= w_next;
   end

   // Grants only from IDLE, so DONE always leaves one dead cycle before the next access.
   always_comb begin
      w_next  = r_state;
      w_grant = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_mem_req || if_req) begin
               w_grant = 1'b1;
               w_next  = ACCESS;
            end
         end
         ACCESS: if (w_cnt_zero) w_next = DONE;
         DONE:   w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_owner     <= OWN_IF;
         r_we        <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_if_addr   <= '0;
         r_if_rdata  <= '0;
         r_mem_rdata <= '0;
      end else begin
         if (w_grant) begin
            if (w_mem_req) begin
               r_owner <= OWN_MEM;
               r_we    <= mem_w_en;
               r_addr  <= w_mem_off[SRAM_AW+1:2];
               r_wdata <= mem_wdata;
            end else begin
               r_owner   <= OWN_IF;
               r_we      <= 1'b0;
               r_addr    <= if_addr[SRAM_AW+1:2];
               r_wdata   <= '0;
               r_if_addr <= if_addr;
            end
         end
         if (w_access && w_cnt_zero && !r_we) begin
            if (r_owner == OWN_MEM)
               r_mem_rdata <= sram_rdata;
            else
               r_if_rdata  <= sram_rdata;
         end
      end
   end

   assign sram_addr  = r_addr;
   assign sram_wdata = r_wdata;
   assign sram_we    = w_access & r_we;
   assign sram_oe    = w_access & ~r_we;
   assign if_rdata   = r_if_rdata;
   assign mem_rdata  = r_mem_rdata;
   assign mem_ready  = w_done & (r_owner == OWN_MEM);
   // A flushed or redirected fetch completes silently so the stale word is never handed back.
   assign if_ready   = w_done & (r_owner == OWN_IF) & if_req & (if_addr == r_if_addr);
   assign mem_freeze = w_mem_req & ~mem_ready;
   assign if_freeze  = (if_req & ~if_ready) | mem_freeze;

`ifdef MEM_ARB_PERF_EN
   logic [31:0] r_perf_if, r_perf_mem;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_perf_if  <= '0;
         r_perf_mem <= '0;
      end else begin
         if (if_freeze && (r_perf_if != '1))   r_perf_if  <= r_perf_if + 1'b1;
         if (mem_freeze && (r_perf_mem != '1)) r_perf_mem <= r_perf_mem + 1'b1;
      end
   end

   assign perf_if_stall  = r_perf_if;
   assign perf_mem_stall = r_perf_mem;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a timeline-based transaction model and SRAM model.
module tb_mem_arbiter;

   localparam int W = 4;

   logic        clk, rst;
   logic        if_req, mem_r_en, mem_w_en;
   logic [31:0] if_addr, mem_addr, mem_wdata;
   logic [31:0] if_rdata, mem_rdata, sram_wdata, sram_rdata;
   logic [15:0] sram_addr;
   logic        if_ready, if_freeze, mem_ready, mem_freeze, sram_we, sram_oe;
`ifdef MEM_ARB_PERF_EN
   logic [31:0] perf_if_stall, perf_mem_stall;
`endif

   int errors = 0;
   int checks = 0;

   mem_arbiter dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
      .if_ready(if_ready), .if_freeze(if_freeze),
      .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .mem_freeze(mem_freeze),
      .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
      .sram_we(sram_we), .sram_oe(sram_oe)
`ifdef MEM_ARB_PERF_EN
     ,.perf_if_stall(perf_if_stall), .perf_mem_stall(perf_mem_stall)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // External SRAM model
   logic [31:0] sram [0:63];
   assign sram_rdata = sram[sram_addr[5:0]];
   always @(posedge clk) if (sram_we) sram[sram_addr[5:0]] <= sram_wdata;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int mem_word(input logic [31:0] a);
      return int'(((a - 32'd1024) >> 2) & 32'hFFFF);
   endfunction

   // Transaction model: a grant at edge g means access cycles after edges g..g+W-1,
   // completion after edge g+W, and the next grant no earlier than edge g+W+2.
   int          e = 0;
   int          m_g = -100;
   int          m_free = 0;
   bit          m_we = 0, m_own_mem = 0;
   logic [15:0] m_addr = '0;
   logic [31:0] m_wdata = '0, m_ifaddr = '0, m_if_rd = '0, m_mem_rd = '0;
   logic [31:0] m_sram [0:63];

   always @(posedge clk) e <= e + 1;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_g      <= -100;
         m_free   <= 0;
         m_if_rd  <= '0;
         m_mem_rd <= '0;
      end else begin
         if ((e + 1 >= m_free) && (mem_r_en || mem_w_en || if_req)) begin
            m_g    <= e + 1;
            m_free <= e + 1 + W + 2;
            if (mem_r_en || mem_w_en) begin
               m_own_mem <= 1'b1;
               m_we      <= mem_w_en;
               m_addr    <= 16'(mem_word(mem_addr));
               m_wdata   <= mem_wdata;
               if (mem_w_en) m_sram[mem_word(mem_addr) % 64] <= mem_wdata;
            end else begin
               m_own_mem <= 1'b0;
               m_we      <= 1'b0;
               m_addr    <= 16'(if_addr >> 2);
               m_ifaddr  <= if_addr;
            end
         end
         if ((e + 1 == m_g + W) && !m_we) begin
            if (m_own_mem) m_mem_rd <= m_sram[m_addr[5:0]];
            else           m_if_rd  <= m_sram[m_addr[5:0]];
         end
      end
   end

   // Per-cycle comparison against the model
   initial begin
      forever begin
         int  k;
         bit  acc, done, x_ifr, x_memr, x_memf;
         @(negedge clk);
         k      = e - m_g;
         acc    = (k >= 0) && (k < W);
         done   = (k == W);
         x_memr = done && m_own_mem;
         x_ifr  = done && !m_own_mem && if_req && (if_addr == m_ifaddr);
         x_memf = (mem_r_en || mem_w_en) && !x_memr;
         chk("sram_oe", 32'(sram_oe), 32'(acc && !m_we));
         chk("sram_we", 32'(sram_we), 32'(acc && m_we));
         if (acc) chk("sram_addr", 32'(sram_addr), 32'(m_addr));
         if (acc && m_we) chk("sram_wdata", sram_wdata, m_wdata);
         chk("mem_ready", 32'(mem_ready), 32'(x_memr));
         chk("if_ready", 32'(if_ready), 32'(x_ifr));
         chk("mem_freeze", 32'(mem_freeze), 32'(x_memf));
         chk("if_freeze", 32'(if_freeze), 32'((if_req && !x_ifr) || x_memf));
         chk("if_rdata", if_rdata, m_if_rd);
         chk("mem_rdata", mem_rdata, m_mem_rd);
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Returns cycle index (1 = current cycle) of the ready pulse and strobe-cycle count.
   task automatic wait_ready(input bit is_mem, output int n, output int nstb);
      n = 0;
      nstb = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (sram_oe || sram_we) nstb++;
         if (is_mem ? mem_ready : if_ready) begin
            n = i;
            break;
         end
         tick();
      end
      if (n == 0) chk("ready_timeout", 32'(is_mem ? mem_ready : if_ready), 32'd1);
   endtask

   initial begin
      int n, ns, nr;
      for (int i = 0; i < 64; i++) begin
         sram[i]   = 32'hAAAA0000 + 32'(i);
         m_sram[i] = 32'hAAAA0000 + 32'(i);
      end
      sram[2]  = 32'hE3A00001; m_sram[2]  = 32'hE3A00001;
      sram[16] = 32'h16161616; m_sram[16] = 32'h16161616;
      if_req = 0; mem_r_en = 0; mem_w_en = 0;
      if_addr = '0; mem_addr = '0; mem_wdata = '0;
      rst = 1'b1;
      #1 rst = 1'b0;
      #2;
      chk("rst_sram_oe", 32'(sram_oe), 32'd0);
      chk("rst_if_rdata", if_rdata, 32'd0);
      repeat (2) tick();
      rst = 1'b1;
      tick();

      // Plain fetch of word 2
      if_req = 1; if_addr = 32'h8;
      wait_ready(0, n, ns);
      chk("fetch_latency", 32'(n), 32'd6);
      chk("fetch_oe_cycles", 32'(ns), 32'd4);
      chk("fetch_data", if_rdata, 32'hE3A00001);
      tick(); if_req = 0;

      // Store to 1028 -> word 1, then load it back
      mem_w_en = 1; mem_addr = 32'd1028; mem_wdata = 32'h1234;
      wait_ready(1, n, ns);
      chk("store_latency", 32'(n), 32'd6);
      chk("store_we_cycles", 32'(ns), 32'd4);
      chk("store_sram_word", sram[1], 32'h1234);
      tick(); mem_w_en = 0; mem_r_en = 1;
      wait_ready(1, n, ns);
      chk("load_data", mem_rdata, 32'h1234);
      tick();

      // Read and write both set behave as a write; mem_rdata keeps the prior load
      mem_w_en = 1; mem_addr = 32'd1036; mem_wdata = 32'hBEEF;
      wait_ready(1, n, ns);
      chk("rw_sram_word", sram[3], 32'hBEEF);
      chk("rw_rdata_kept", mem_rdata, 32'h1234);
      tick(); mem_w_en = 0; mem_r_en = 0;

      // Simultaneous requests: MEM first, IF after the dead cycle
      if_req = 1; if_addr = 32'hC; mem_r_en = 1; mem_addr = 32'd1044;
      wait_ready(1, n, ns);
      chk("prio_mem_latency", 32'(n), 32'd6);
      chk("prio_mem_data", mem_rdata, 32'hAAAA0005);
      tick(); mem_r_en = 0;
      wait_ready(0, n, ns);
      chk("prio_if_latency", 32'(n), 32'd6);
      chk("prio_if_data", if_rdata, 32'hBEEF);
      tick(); if_req = 0;

      // Branch flush: address redirected during the access
      if_req = 1; if_addr = 32'h10;
      tick(); if_addr = 32'h40;
      wait_ready(0, n, ns);
      chk("flush_latency", 32'(n), 32'd11);
      chk("flush_oe_cycles", 32'(ns), 32'd8);
      chk("flush_data", if_rdata, 32'h16161616);
      tick(); if_req = 0;

      // Reset during a write access
      mem_w_en = 1; mem_addr = 32'd1048; mem_wdata = 32'h55;
      tick(); tick();
      chk("pre_rst_we", 32'(sram_we), 32'd1);
      #1 rst = 1'b0; mem_w_en = 0;
      #1;
      chk("rst_we_drop", 32'(sram_we), 32'd0);
      chk("rst_oe_drop", 32'(sram_oe), 32'd0);
      chk("rst_mem_rdata", mem_rdata, 32'd0);
      tick(); rst = 1'b1;
      nr = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (mem_ready || if_ready) nr++;
         tick();
      end
      chk("rst_no_ready", 32'(nr), 32'd0);

`ifdef MEM_ARB_PERF_EN
      chk("perf_if_zero", perf_if_stall, 32'd0);
      if_req = 1; if_addr = 32'h8;
      for (int i = 0; i < 3; i++) begin
         wait_ready(0, n, ns);
         tick();
      end
      if_req = 0;
      @(negedge clk);
      chk("perf_if_stall", perf_if_stall, 32'd15);
      chk("perf_mem_stall", perf_mem_stall, 32'd0);
`endif

      repeat (3) tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
